l2_lookup_sched: RTL and testbench

Sequences every L2 tag/state lookup and shares the lookup datapath between two requesters: the CPU request channel and the forward channel.
- Arbitrates one transaction at a time.
- Issues the tag/state RAM read for the selected set and strobes the tag/state buffer capture.
- Pulses the lookup block's enable with the correct mode, then holds a completion handshake until the consumer FSM takes it.
- Sits between the input channel queues, the tag/state RAMs and the lookup block.

---
 rtl/l2_lookup_sched_if.sv | 41 ++++
 rtl/l2_lookup_sched.sv | 172 +++++++++++++++++
 tb/tb_l2_lookup_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/l2_lookup_sched_if.sv
// l2_lookup_sched_if: bundle of every handshake/bus signal around the L2 lookup scheduler.
//   Request channel : req_valid, req_set -> req_ready
//   Forward channel : fwd_valid, fwd_set -> fwd_ready
//   Tag/state RAM   : rd_en, rd_set, buf_load
//   Lookup block    : lookup_en, lookup_mode
//   Completion      : done_valid, done_src, done_set <- done_ready
//   Status          : busy
// slave  : scheduler side (drives ready/RAM/lookup/done/busy).
// master : environment side (queues, RAM wrapper, lookup block, consumer FSM).
interface l2_lookup_sched_if #(
    parameter int unsigned SET_BITS = 9
);
    logic                req_valid;
    logic [SET_BITS-1:0] req_set;
    logic                req_ready;
    logic                fwd_valid;
    logic [SET_BITS-1:0] fwd_set;
    logic                fwd_ready;
    logic                rd_en;
    logic [SET_BITS-1:0] rd_set;
    logic                buf_load;
    logic                lookup_en;
    logic                lookup_mode;
    logic                done_valid;
    logic                done_src;
    logic [SET_BITS-1:0] done_set;
    logic                done_ready;
    logic                busy;

    modport slave (
        input  req_valid, req_set, fwd_valid, fwd_set, done_ready,
        output req_ready, fwd_ready, rd_en, rd_set, buf_load,
               lookup_en, lookup_mode, done_valid, done_src, done_set, busy
    );

    modport master (
        output req_valid, req_set, fwd_valid, fwd_set, done_ready,
        input  req_ready, fwd_ready, rd_en, rd_set, buf_load,
               lookup_en, lookup_mode, done_valid, done_src, done_set, busy
    );
endinterface

// File: rtl/l2_lookup_sched.sv
// l2_lookup_sched: arbitrates the CPU request and forward channels onto the single
// L2 tag/state lookup path, one transaction at a time:
//   IDLE (grant) -> READ (RAM read) -> WAIT (RD_LAT cycles, buffer capture on last)
//   -> LOOKUP (one-cycle enable) -> RESP (hold completion until consumed) -> IDLE.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : l2_lookup_sched_if.slave (channel handshakes, RAM read, lookup, completion, busy)
// req_ready/fwd_ready are combinational from the valids in IDLE; all other outputs
// are registered or come straight from registered transaction state.

`ifndef L2_LOOKUP
`define L2_LOOKUP 1'b0
`endif
`ifndef L2_LOOKUP_FWD
`define L2_LOOKUP_FWD 1'b1
`endif

module l2_lookup_sched #(
    parameter int unsigned SET_BITS   = 9,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    l2_lookup_sched_if.slave  bus
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned STV_W = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_LOOKUP = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_d;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    wait_cnt_d;
    logic [STV_W-1:0]    starve_cnt;
    logic [SET_BITS-1:0] set_q;
    logic                src_q;

    logic                rd_en_q;
    logic                buf_load_q;
    logic                lookup_en_q;
    logic                lookup_mode_q;
    logic                done_valid_q;
    logic                busy_q;

    logic                idle_c;
    logic                starve_hit_c;
    logic                grant_fwd_c;
    logic                grant_req_c;
    logic                wait_done_c;

    // Arbitration: forward has priority unless the waiting request has hit the starvation limit.
    // Gated with rst so no ready can escape while reset is asserted.
    assign idle_c       = rst && (state == ST_IDLE);
    assign starve_hit_c = (starve_cnt == STV_W'(STARVE_MAX));
    assign grant_fwd_c  = idle_c && bus.fwd_valid && !(bus.req_valid && starve_hit_c);
    assign grant_req_c  = idle_c && bus.req_valid && !grant_fwd_c;
    assign wait_done_c  = (wait_cnt == '0);

    assign bus.req_ready = grant_req_c;
    assign bus.fwd_ready = grant_fwd_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (grant_fwd_c || grant_req_c) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                wait_cnt_d = CNT_W'(RD_LAT - 1);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done_c) begin
                    state_d = ST_LOOKUP;
                end else begin
                    wait_cnt_d = wait_cnt - CNT_W'(1);
                end
            end
            ST_LOOKUP: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction context latched at accept; held until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_q <= '0;
            src_q <= 1'b0;
        end else if (grant_fwd_c) begin
            set_q <= bus.fwd_set;
            src_q <= 1'b1;
        end else if (grant_req_c) begin
            set_q <= bus.req_set;
            src_q <= 1'b0;
        end
    end

    // Starvation counter: counts forward wins over a waiting request, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_req_c) begin
            starve_cnt <= '0;
        end else if (grant_fwd_c && bus.req_valid && !starve_hit_c) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Registered strobes decoded from the next state so they align with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q       <= 1'b0;
            buf_load_q    <= 1'b0;
            lookup_en_q   <= 1'b0;
            lookup_mode_q <= `L2_LOOKUP;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rd_en_q      <= (state_d == ST_READ);
            buf_load_q   <= (state_d == ST_WAIT) && (wait_cnt_d == '0);
            lookup_en_q  <= (state_d == ST_LOOKUP);
            done_valid_q <= (state_d == ST_RESP);
            busy_q       <= (state_d != ST_IDLE);
            if (state_d == ST_LOOKUP) begin
                lookup_mode_q <= src_q ? `L2_LOOKUP_FWD : `L2_LOOKUP;
            end
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_set      = set_q;
    assign bus.buf_load    = buf_load_q;
    assign bus.lookup_en   = lookup_en_q;
    assign bus.lookup_mode = lookup_mode_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_src    = src_q;
    assign bus.done_set    = set_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_l2_lookup_sched.sv
// tb_l2_lookup_sched: directed self-checking bench for l2_lookup_sched.
// Two instances share clk/rst: u_d1 (RD_LAT=1) and u_d3 (RD_LAT=3), both STARVE_MAX=4.
// Inputs are driven just after the falling edge; outputs are checked 1 time unit later.
module tb_l2_lookup_sched;

    localparam int unsigned SB = 9;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   got;

    l2_lookup_sched_if #(.SET_BITS(SB)) i1 ();
    l2_lookup_sched_if #(.SET_BITS(SB)) i3 ();

    l2_lookup_sched #(.SET_BITS(SB), .RD_LAT(1), .STARVE_MAX(4)) u_d1 (
        .clk (clk),
        .rst (rst),
        .bus (i1.slave)
    );

    l2_lookup_sched #(.SET_BITS(SB), .RD_LAT(3), .STARVE_MAX(4)) u_d3 (
        .clk (clk),
        .rst (rst),
        .bus (i3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        i1.req_valid = 1'b0; i1.req_set = '0; i1.fwd_valid = 1'b0; i1.fwd_set = '0; i1.done_ready = 1'b0;
        i3.req_valid = 1'b0; i3.req_set = '0; i3.fwd_valid = 1'b0; i3.fwd_set = '0; i3.done_ready = 1'b1;

        // Reset state
        repeat (2) cyc();
        #1;
        chk("rst_busy",   32'(i1.busy), 0);
        chk("rst_rd_en",  32'(i1.rd_en), 0);
        chk("rst_dvalid", 32'(i1.done_valid), 0);
        chk("rst_mode",   32'(i1.lookup_mode), 0);
        chk("rst_rdset",  32'(i1.rd_set), 0);
        cyc(); rst = 1'b1;

        // Single request, RD_LAT=1
        cyc(); i1.req_valid = 1'b1; i1.req_set = 9'h005; i1.done_ready = 1'b1; #1;
        chk("t1_req_ready", 32'(i1.req_ready), 1);
        chk("t1_fwd_ready", 32'(i1.fwd_ready), 0);
        chk("t1_busy0",     32'(i1.busy), 0);
        cyc(); i1.req_valid = 1'b0; #1;
        chk("t1_rd_en",  32'(i1.rd_en), 1);
        chk("t1_rd_set", 32'(i1.rd_set), 32'h005);
        chk("t1_busy1",  32'(i1.busy), 1);
        cyc(); #1;
        chk("t1_buf_load", 32'(i1.buf_load), 1);
        chk("t1_rd_en_off", 32'(i1.rd_en), 0);
        cyc(); #1;
        chk("t1_lookup_en", 32'(i1.lookup_en), 1);
        chk("t1_mode",      32'(i1.lookup_mode), 0);
        chk("t1_buf_off",   32'(i1.buf_load), 0);
        cyc(); #1;
        chk("t1_done_valid", 32'(i1.done_valid), 1);
        chk("t1_done_src",   32'(i1.done_src), 0);
        chk("t1_done_set",   32'(i1.done_set), 32'h005);
        chk("t1_lookup_off", 32'(i1.lookup_en), 0);
        cyc(); #1;
        chk("t1_busy_end",  32'(i1.busy), 0);
        chk("t1_done_off",  32'(i1.done_valid), 0);

        // Single forward, RD_LAT=3
        cyc(); i3.fwd_valid = 1'b1; i3.fwd_set = 9'h1FF; #1;
        chk("t2_fwd_ready", 32'(i3.fwd_ready), 1);
        cyc(); i3.fwd_valid = 1'b0; #1;
        chk("t2_rd_en",  32'(i3.rd_en), 1);
        chk("t2_rd_set", 32'(i3.rd_set), 32'h1FF);
        cyc(); #1; chk("t2_buf_t2", 32'(i3.buf_load), 0);
        cyc(); #1; chk("t2_buf_t3", 32'(i3.buf_load), 0);
        cyc(); #1; chk("t2_buf_t4", 32'(i3.buf_load), 1);
        cyc(); #1;
        chk("t2_lookup_en", 32'(i3.lookup_en), 1);
        chk("t2_mode",      32'(i3.lookup_mode), 1);
        chk("t2_buf_t5",    32'(i3.buf_load), 0);
        cyc(); #1;
        chk("t2_done_valid", 32'(i3.done_valid), 1);
        chk("t2_done_src",   32'(i3.done_src), 1);
        chk("t2_done_set",   32'(i3.done_set), 32'h1FF);
        cyc(); #1;
        chk("t2_busy_end", 32'(i3.busy), 0);

        // Starvation: both valid continuously -> F F F F R F F F F R
        cyc(); i1.req_valid = 1'b1; i1.req_set = 9'h0A0; i1.fwd_valid = 1'b1; i1.fwd_set = 9'h0B0;
        for (int g = 0; g < 10; g++) begin
            got = -1;
            for (int w = 0; w < 12; w++) begin
                #1;
                if (i1.req_ready || i1.fwd_ready) begin
                    chk("t3_one_ready", 32'(i1.req_ready & i1.fwd_ready), 0);
                    got = i1.fwd_ready ? 1 : 0;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("t3_grant%0d_is_fwd", g), 32'(got), (g % 5 == 4) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        i1.req_valid = 1'b0; i1.fwd_valid = 1'b0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (!i1.busy) break;
            @(negedge clk);
        end
        chk("t3_drain", 32'(i1.busy), 0);

        // Completion held off by consumer for 10 cycles
        cyc(); i1.req_valid = 1'b1; i1.req_set = 9'h02A; i1.done_ready = 1'b0; #1;
        chk("t4_req_ready", 32'(i1.req_ready), 1);
        cyc(); i1.req_valid = 1'b0; i1.fwd_valid = 1'b1; i1.fwd_set = 9'h0C3;
        cyc(); cyc();
        cyc(); #1;
        chk("t4_done_valid", 32'(i1.done_valid), 1);
        chk("t4_done_set",   32'(i1.done_set), 32'h02A);
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            chk("t4_hold_valid", 32'(i1.done_valid), 1);
            chk("t4_hold_set",   32'(i1.done_set), 32'h02A);
            chk("t4_hold_src",   32'(i1.done_src), 0);
            chk("t4_hold_noready", 32'(i1.fwd_ready | i1.req_ready), 0);
        end
        cyc(); i1.done_ready = 1'b1; #1;
        chk("t4_hs_noready", 32'(i1.fwd_ready), 0);
        chk("t4_hs_valid",   32'(i1.done_valid), 1);
        cyc(); #1;
        chk("t4_next_grant", 32'(i1.fwd_ready), 1);
        chk("t4_next_busy",  32'(i1.busy), 0);
        cyc(); i1.fwd_valid = 1'b0; #1;
        chk("t4_fwd_rdset", 32'(i1.rd_set), 32'h0C3);
        for (int w = 0; w < 20; w++) begin
            #1;
            if (!i1.busy) break;
            @(negedge clk);
        end
        chk("t4_drain", 32'(i1.busy), 0);
        chk("t4_mode_held", 32'(i1.lookup_mode), 1);

        // Reset pulsed during WAIT
        cyc(); i1.req_valid = 1'b1; i1.req_set = 9'h033; #1;
        chk("t5_req_ready", 32'(i1.req_ready), 1);
        cyc(); i1.req_valid = 1'b0; #1;
        chk("t5_rd_en", 32'(i1.rd_en), 1);
        cyc(); #1;
        chk("t5_in_wait", 32'(i1.buf_load), 1);
        rst = 1'b0; i1.req_valid = 1'b1; #1;
        chk("t5_rst_rd_en",    32'(i1.rd_en), 0);
        chk("t5_rst_buf_load", 32'(i1.buf_load), 0);
        chk("t5_rst_lookup",   32'(i1.lookup_en), 0);
        chk("t5_rst_mode",     32'(i1.lookup_mode), 0);
        chk("t5_rst_dvalid",   32'(i1.done_valid), 0);
        chk("t5_rst_busy",     32'(i1.busy), 0);
        chk("t5_rst_rdset",    32'(i1.rd_set), 0);
        chk("t5_rst_doneset",  32'(i1.done_set), 0);
        chk("t5_rst_ready",    32'(i1.req_ready), 0);
        cyc(); rst = 1'b1; #1;
        chk("t5_re_accept", 32'(i1.req_ready), 1);
        cyc(); i1.req_valid = 1'b0; #1;
        chk("t5_re_rd_en",  32'(i1.rd_en), 1);
        chk("t5_re_rd_set", 32'(i1.rd_set), 32'h033);
        cyc(); cyc();
        cyc(); #1;
        chk("t5_re_done",     32'(i1.done_valid), 1);
        chk("t5_re_done_set", 32'(i1.done_set), 32'h033);
        cyc(); #1;
        chk("t5_re_idle", 32'(i1.busy), 0);

        // Back-to-back requests 0x10 then 0x11
        cyc(); i1.req_valid = 1'b1; i1.req_set = 9'h010; i1.done_ready = 1'b1; #1;
        chk("t6_acc1", 32'(i1.req_ready), 1);
        cyc(); i1.req_set = 9'h011; #1;
        chk("t6_t1_noready", 32'(i1.req_ready), 0);
        chk("t6_t1_rdset",   32'(i1.rd_set), 32'h010);
        cyc(); #1;
        chk("t6_t2_noready", 32'(i1.req_ready), 0);
        cyc(); #1;
        chk("t6_t3_lookup", 32'(i1.lookup_en), 1);
        cyc(); #1;
        chk("t6_t4_done",     32'(i1.done_valid), 1);
        chk("t6_t4_done_set", 32'(i1.done_set), 32'h010);
        chk("t6_t4_noready",  32'(i1.req_ready), 0);
        chk("t6_t4_lookup0",  32'(i1.lookup_en), 0);
        cyc(); #1;
        chk("t6_acc2",    32'(i1.req_ready), 1);
        chk("t6_t5_done", 32'(i1.done_valid), 0);
        cyc(); i1.req_valid = 1'b0; #1;
        chk("t6_rd_en2",  32'(i1.rd_en), 1);
        chk("t6_rd_set2", 32'(i1.rd_set), 32'h011);
        chk("t6_t6_lookup0", 32'(i1.lookup_en), 0);
        cyc(); #1;
        chk("t6_t7_lookup0", 32'(i1.lookup_en), 0);
        cyc(); #1;
        chk("t6_t8_lookup", 32'(i1.lookup_en), 1);
        cyc(); #1;
        chk("t6_t9_done",     32'(i1.done_valid), 1);
        chk("t6_t9_done_set", 32'(i1.done_set), 32'h011);
        cyc(); #1;
        chk("t6_idle", 32'(i1.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
